// File: rtl/ic_axi_rd_master_if.sv
// ---------------------------------------------------------------------------
// ic_axi_rd_master_if
// Tiny-AXI read channels (AR + R) between the I-cache refill master and the
// memory-side slave.
//   master modport : drives AR payload/arvalid and rready
//   slave  modport : drives arready and the R payload/rvalid
// Signals:
//   arid[IDW], araddr[32], arlen[8], arsize[3], arburst[2], arvalid, arready
//   rid[IDW], rdata[32], rresp[2], rlast, rvalid, rready
// ---------------------------------------------------------------------------
interface ic_axi_rd_if #(
    parameter int IDW = 4
) ();
    logic [IDW-1:0] arid;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arvalid;
    logic           arready;

    logic [IDW-1:0] rid;
    logic [31:0]    rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ic_axi_rd_master.sv
// ---------------------------------------------------------------------------
// ic_axi_rd_master
// Instruction-cache refill read master. Takes a one-cycle refill request from
// the I-cache lookup stage, issues a single 4-beat INCR burst (32-bit beats)
// for the aligned 16-byte line, assembles the beats into a 128-bit line and
// returns it with a one-cycle valid pulse.
//
// Ports:
//   clk              system clock
//   rst_n            synchronous active-low reset
//   rst_pipe         pipeline flush; the in-flight refill still completes on
//                    AXI but its result is not delivered
//   icr_start_rq     one-cycle refill request (ignored unless idle)
//   ic_rin_addr      refill address, any byte within the line
//   rdat_m_data      assembled line, word k = beat k
//   ic_rdat_m_valid  one-cycle line-valid pulse
//   ic_finish_mrd    one-cycle pulse at the end of every burst
//   ic_rd_err        one-cycle pulse with ic_finish_mrd if the burst had an error
//   ic_rd_busy       high from request acceptance through the finish cycle
//   axi              AR/R tiny-AXI channels (master side)
// ---------------------------------------------------------------------------
module ic_axi_rd_master #(
    parameter int             IDW    = 4,
    parameter logic [IDW-1:0] AXI_ID = 4'h1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rst_pipe,
    input  logic          icr_start_rq,
    input  logic [31:0]   ic_rin_addr,
    output logic [127:0]  rdat_m_data,
    output logic          ic_rdat_m_valid,
    output logic          ic_finish_mrd,
    output logic          ic_rd_err,
    output logic          ic_rd_busy,
    ic_axi_rd_if.master   axi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AREQ = 2'd1,
        RDAT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [31:0]   r_araddr;
    logic [127:0]  r_data;
    logic [1:0]    r_cnt;
    logic          r_err;
    logic          r_discard;

    logic          w_accept;
    logic          w_ar_hs;
    logic          w_beat;
    logic          w_beat_err;
    logic          w_unused;

    // Beat counter advances to 3 and then sticks, so any surplus beats land
    // on word 3 instead of wrapping over word 0.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    // RID is deliberately not checked against AXI_ID.
    assign w_unused = ^axi.rid;

    assign w_accept = (r_state == IDLE) & icr_start_rq;
    assign w_ar_hs  = (r_state == AREQ) & axi.arready;
    assign w_beat   = (r_state == RDAT) & axi.rvalid;

    // A beat is erroneous if the slave reports non-OKAY, or if rlast does not
    // coincide with the fourth beat (early rlast, or a fourth beat without
    // rlast which means the burst is running long).
    assign w_beat_err = (axi.rresp != 2'b00) | ((r_cnt == 2'd3) != axi.rlast);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (icr_start_rq) begin
                    w_next = AREQ;
                end
            end
            AREQ: begin
                if (axi.arready) begin
                    w_next = RDAT;
                end
            end
            RDAT: begin
                if (axi.rvalid && axi.rlast) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                // Requests arriving here are dropped; the requester retries.
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Address latch, line assembly and burst status flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_araddr  <= 32'h0;
            r_data    <= 128'h0;
            r_cnt     <= 2'd0;
            r_err     <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            if (w_accept) begin
                r_araddr  <= {ic_rin_addr[31:4], 4'h0};
                r_cnt     <= 2'd0;
                r_err     <= 1'b0;
                r_discard <= 1'b0;
            end

            // A flush cannot abort the AXI transaction, so it only marks the
            // result as unwanted; the burst still drains to rlast.
            if (rst_pipe && ((r_state == AREQ) || (r_state == RDAT))) begin
                r_discard <= 1'b1;
            end

            if (w_beat) begin
                r_data[{r_cnt, 5'd0} +: 32] <= axi.rdata;
                r_cnt                       <= sat_inc(r_cnt);
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Unused by the datapath beyond this point; keeps the AR hand-off visible.
    logic w_ar_hs_unused;
    assign w_ar_hs_unused = w_ar_hs;

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = 8'd3;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (r_state == AREQ);
    assign axi.rready  = (r_state == RDAT);

    assign rdat_m_data     = r_data;
    assign ic_finish_mrd   = (r_state == DONE);
    // A flush landing in the finish cycle itself must also kill the pulse.
    assign ic_rdat_m_valid = (r_state == DONE) & ~r_discard & ~rst_pipe;
    assign ic_rd_err       = (r_state == DONE) & r_err;
    assign ic_rd_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ic_axi_rd_master.sv
module tb_ic_axi_rd_master;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rst_pipe;
    logic          icr_start_rq;
    logic [31:0]   ic_rin_addr;
    logic [127:0]  rdat_m_data;
    logic          ic_rdat_m_valid;
    logic          ic_finish_mrd;
    logic          ic_rd_err;
    logic          ic_rd_busy;

    ic_axi_rd_if #(.IDW(4)) axi ();

    ic_axi_rd_master #(.IDW(4), .AXI_ID(4'h1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rst_pipe        (rst_pipe),
        .icr_start_rq    (icr_start_rq),
        .ic_rin_addr     (ic_rin_addr),
        .rdat_m_data     (rdat_m_data),
        .ic_rdat_m_valid (ic_rdat_m_valid),
        .ic_finish_mrd   (ic_finish_mrd),
        .ic_rd_err       (ic_rd_err),
        .ic_rd_busy      (ic_rd_busy),
        .axi             (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Transaction-level reference model: tracks whether a refill is owned,
    // whether its address is still being offered, the beats received so far
    // and whether the burst just finished. Checked every falling edge, then
    // advanced using the inputs the DUT will sample at the next rising edge.
    // -----------------------------------------------------------------------
    bit          m_init = 1'b0;
    bit          m_busy, m_arp, m_fin, m_disc, m_err;
    int          m_nb;
    int          idx;
    logic [31:0] m_addr;
    logic [31:0] m_line [4];
    int          n_valid = 0;
    int          n_fin   = 0;

    always @(negedge clk) begin
        if (m_init) begin
            chk1("arvalid", axi.arvalid, m_arp);
            chkw("araddr", 128'(axi.araddr), 128'(m_addr));
            chk1("rready", axi.rready, m_busy && !m_arp && !m_fin);
            chk1("finish", ic_finish_mrd, m_fin);
            chk1("valid", ic_rdat_m_valid, m_fin && !m_disc && !rst_pipe);
            chk1("rd_err", ic_rd_err, m_fin && m_err);
            chk1("busy", ic_rd_busy, m_busy);
            chkw("line", rdat_m_data, {m_line[3], m_line[2], m_line[1], m_line[0]});
            chkw("arid", 128'(axi.arid), 128'(4'h1));
            chkw("arlen", 128'(axi.arlen), 128'(8'd3));
            chkw("arsize", 128'(axi.arsize), 128'(3'd2));
            chkw("arburst", 128'(axi.arburst), 128'(2'd1));
            if (ic_rdat_m_valid) n_valid++;
            if (ic_finish_mrd)   n_fin++;
        end

        if (!rst_n) begin
            m_init = 1'b1;
            m_busy = 1'b0; m_arp = 1'b0; m_fin = 1'b0; m_disc = 1'b0; m_err = 1'b0;
            m_nb   = 0;
            m_addr = 32'h0;
            for (int i = 0; i < 4; i++) m_line[i] = 32'h0;
        end else if (m_init) begin
            if (m_fin) begin
                m_fin  = 1'b0;
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (icr_start_rq) begin
                    m_busy = 1'b1;
                    m_arp  = 1'b1;
                    m_addr = ic_rin_addr & 32'hFFFF_FFF0;
                    m_nb   = 0;
                    m_err  = 1'b0;
                    m_disc = 1'b0;
                end
            end else begin
                if (rst_pipe) m_disc = 1'b1;
                if (m_arp) begin
                    if (axi.arready) m_arp = 1'b0;
                end else if (axi.rvalid) begin
                    idx = (m_nb < 3) ? m_nb : 3;
                    m_line[idx] = axi.rdata;
                    m_nb++;
                    if (axi.rresp != 2'b00) m_err = 1'b1;
                    if (axi.rlast) begin
                        if (m_nb != 4) m_err = 1'b1;
                        m_fin = 1'b1;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // -----------------------------------------------------------------------
    int gaps [4] = '{0, 2, 0, 1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] a);
        icr_start_rq = 1'b1;
        ic_rin_addr  = a;
        step();
        icr_start_rq = 1'b0;
    endtask

    task automatic ar_phase(input int stall, input logic [31:0] ea);
        axi.arready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk1("ar_stall_valid", axi.arvalid, 1'b1);
            chkw("ar_stall_addr", 128'(axi.araddr), 128'(ea));
            step();
        end
        chk1("ar_offered", axi.arvalid, 1'b1);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
    endtask

    task automatic beat(input int gap, input logic [31:0] d, input logic [1:0] resp, input logic last);
        axi.rvalid = 1'b0;
        repeat (gap) step();
        axi.rvalid = 1'b1;
        axi.rdata  = d;
        axi.rresp  = resp;
        axi.rlast  = last;
        step();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
    endtask

    // Beat k carries 0x11111111*(k+1); returns in the cycle after the last beat.
    task automatic burst(input logic [31:0] a, input int stall, input int nb,
                         input int bad, input int lastk, input bit gapped);
        request(a);
        ar_phase(stall, a & 32'hFFFF_FFF0);
        for (int k = 0; k < nb; k++) begin
            beat((gapped && k < 4) ? gaps[k] : 0, 32'h1111_1111 * (k + 1),
                 (k == bad) ? 2'b10 : 2'b00, k == lastk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    int v0, f0;

    initial begin
        rst_n = 1'b0; rst_pipe = 1'b0; icr_start_rq = 1'b0; ic_rin_addr = 32'h0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0;
        axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = 4'h5;
        repeat (3) step();

        // Reset state
        chk1("rst_busy", ic_rd_busy, 1'b0);
        chk1("rst_arvalid", axi.arvalid, 1'b0);
        chk1("rst_rready", axi.rready, 1'b0);
        chk1("rst_valid", ic_rdat_m_valid, 1'b0);
        chkw("rst_data", rdat_m_data, 128'h0);
        rst_n = 1'b1;
        step();

        // Basic refill, zero wait
        burst(32'h0000_1234, 0, 4, -1, 3, 1'b0);
        chkw("basic_araddr", 128'(axi.araddr), 128'(32'h0000_1230));
        chk1("basic_valid", ic_rdat_m_valid, 1'b1);
        chk1("basic_finish", ic_finish_mrd, 1'b1);
        chk1("basic_err", ic_rd_err, 1'b0);
        chkw("basic_line", rdat_m_data, 128'h44444444_33333333_22222222_11111111);
        step();
        chk1("basic_idle", ic_rd_busy, 1'b0);

        // Backpressure: 5 AR stall cycles, rvalid pattern 1,0,0,1,1,0,1
        v0 = n_valid;
        burst(32'h0000_1234, 5, 4, -1, 3, 1'b1);
        chkw("bp_line", rdat_m_data, 128'h44444444_33333333_22222222_11111111);
        step(); step();
        chkw("bp_one_valid", 128'(n_valid - v0), 128'(1));

        // Error response on beat 2
        burst(32'h0000_4008, 0, 4, 2, 3, 1'b0);
        chk1("err_valid", ic_rdat_m_valid, 1'b1);
        chk1("err_flag", ic_rd_err, 1'b1);
        chk1("err_finish", ic_finish_mrd, 1'b1);
        step();

        // Flush during RDAT after beat 1, then a new request one cycle later
        v0 = n_valid; f0 = n_fin;
        request(32'h0000_3000);
        ar_phase(0, 32'h0000_3000);
        beat(0, 32'hA0A0_A0A0, 2'b00, 1'b0);
        beat(0, 32'hA1A1_A1A1, 2'b00, 1'b0);
        rst_pipe = 1'b1;
        step();
        rst_pipe = 1'b0;
        beat(0, 32'hA2A2_A2A2, 2'b00, 1'b0);
        beat(0, 32'hA3A3_A3A3, 2'b00, 1'b1);
        chk1("flush_no_valid", ic_rdat_m_valid, 1'b0);
        chk1("flush_finish", ic_finish_mrd, 1'b1);
        step();
        request(32'h0000_5550);
        chk1("flush_next_busy", ic_rd_busy, 1'b1);
        chk1("flush_next_arvalid", axi.arvalid, 1'b1);
        chkw("flush_next_addr", 128'(axi.araddr), 128'(32'h0000_5550));
        ar_phase(0, 32'h0000_5550);
        for (int k = 0; k < 4; k++) beat(0, 32'hB000_0000 + k, 2'b00, k == 3);
        step();
        chkw("flush_valid_count", 128'(n_valid - v0), 128'(1));
        chkw("flush_fin_count", 128'(n_fin - f0), 128'(2));

        // Back-to-back: request in RDAT and in DONE ignored, after DONE accepted
        request(32'h0000_0100);
        ar_phase(0, 32'h0000_0100);
        beat(0, 32'hC0, 2'b00, 1'b0);
        icr_start_rq = 1'b1; ic_rin_addr = 32'h0000_9990;
        beat(0, 32'hC1, 2'b00, 1'b0);
        icr_start_rq = 1'b0;
        beat(0, 32'hC2, 2'b00, 1'b0);
        beat(0, 32'hC3, 2'b00, 1'b1);
        chkw("b2b_addr_kept", 128'(axi.araddr), 128'(32'h0000_0100));
        icr_start_rq = 1'b1; ic_rin_addr = 32'h0000_7770;
        step();
        ic_rin_addr = 32'h2000_00F8;
        step();
        icr_start_rq = 1'b0;
        chk1("b2b_arvalid", axi.arvalid, 1'b1);
        chkw("b2b_araddr", 128'(axi.araddr), 128'(32'h2000_00F0));
        ar_phase(0, 32'h2000_00F0);
        for (int k = 0; k < 4; k++) beat(0, 32'hD000_0000 + k, 2'b00, k == 3);
        step();

        // Synchronous reset mid-RDAT
        request(32'h0000_0600);
        ar_phase(0, 32'h0000_0600);
        beat(0, 32'hE0, 2'b00, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk1("midrst_busy", ic_rd_busy, 1'b0);
        chk1("midrst_arvalid", axi.arvalid, 1'b0);
        chk1("midrst_rready", axi.rready, 1'b0);
        chk1("midrst_finish", ic_finish_mrd, 1'b0);
        chkw("midrst_data", rdat_m_data, 128'h0);
        chkw("midrst_araddr", 128'(axi.araddr), 128'h0);
        step();

        // Early rlast on beat 1: words 2,3 keep their (reset) contents
        burst(32'h0000_0700, 0, 2, -1, 1, 1'b0);
        chk1("early_err", ic_rd_err, 1'b1);
        chk1("early_valid", ic_rdat_m_valid, 1'b1);
        chkw("early_line", rdat_m_data, 128'h00000000_00000000_22222222_11111111);
        step();

        // Overlong burst: fifth beat overwrites word 3, error flagged
        burst(32'h0000_0800, 0, 5, -1, 4, 1'b0);
        chk1("long_err", ic_rd_err, 1'b1);
        chkw("long_line", rdat_m_data, 128'h55555555_33333333_22222222_11111111);
        step();

        // Flush arriving in the finish cycle itself
        burst(32'h0000_0900, 0, 4, -1, 3, 1'b0);
        rst_pipe = 1'b1;
        #1;
        chk1("donefl_valid", ic_rdat_m_valid, 1'b0);
        chk1("donefl_finish", ic_finish_mrd, 1'b1);
        step();
        rst_pipe = 1'b0;

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
